// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared state encoding and constants for mem_responder
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } mem_resp_state_e;

    localparam int MEM_RESP_DROP_W = 16;

endpackage

// File: rtl/mem_responder_ram.sv
// rtl/mem_responder_ram.sv - single-port word array with write enable and gated registered read
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset so committed writes survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // The read register only moves on an accepted read, so write acks keep the last read value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder; MEM_RESPONDER_STATS_EN enables drop_count
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic                       wr_req,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       busy,
    output logic                       ack,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [MEM_RESP_DROP_W-1:0] drop_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    mem_resp_state_e  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req, accept, we, re;
    logic             unused_addr;

    assign req    = rd_req | wr_req;
    assign accept = req && ((state == IDLE) || (state == ACK));
    // A simultaneous read/write keeps only the write.
    assign we     = accept && wr_req;
    assign re     = accept && rd_req && !wr_req;

    assign unused_addr = ^{addr[1:0], addr[ADDR_WIDTH-1:IDX_W+2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, ACK: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end else if (state == ACK) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT);
    assign ack  = (state == ACK);

    mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .re    (re),
        .idx   (addr[2 +: IDX_W]),
        .wdata (wr_data),
        .rdata (rd_data)
    );

`ifdef MEM_RESPONDER_STATS_EN
    logic                       drop;
    logic [MEM_RESP_DROP_W-1:0] drop_cnt;

    assign drop = (req && !accept) || (accept && rd_req && wr_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 4 and 1
module tb_mem_responder;

`ifdef MEM_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd_req4 = 1'b0, wr_req4 = 1'b0;
    logic [31:0] addr4 = '0, wdata4 = '0;
    logic        busy4, ack4;
    logic [31:0] rd_data4;
    logic [15:0] drop4;

    logic        rd_req1 = 1'b0, wr_req1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic        busy1, ack1;
    logic [31:0] rd_data1;
    logic [15:0] drop1;

    int checks = 0;
    int errors = 0;

    logic [31:0] q4[$];
    logic [31:0] q1[$];
    logic [31:0] m4[int];
    logic [31:0] m1[int];
    logic [31:0] last4 = '0;
    logic [31:0] last1 = '0;
    int          drops4 = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_req(rd_req4), .wr_req(wr_req4), .addr(addr4),
        .wr_data(wdata4), .busy(busy4), .ack(ack4), .rd_data(rd_data4), .drop_count(drop4)
    );

    mem_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req1), .wr_req(wr_req1), .addr(addr1),
        .wr_data(wdata1), .busy(busy1), .ack(ack1), .rd_data(rd_data1), .drop_count(drop1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    // Monitors: pop the expected rd_data for every ack the DUT presents.
    always @(negedge clk) begin
        if (ack4) begin
            if (q4.size() == 0) check("ack4_unexpected", 32'(ack4), 32'd0);
            else check("rd_data4_at_ack", rd_data4, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ack1) begin
            if (q1.size() == 0) check("ack1_unexpected", 32'(ack1), 32'd0);
            else check("rd_data1_at_ack", rd_data1, q1.pop_front());
        end
    end

    // push=1 means the request is accepted and will be acked; the model is updated then.
    task automatic req4(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit push);
        if (push) begin
            if (wr) m4[widx(a)] = d;
            else last4 = m4[widx(a)];
            q4.push_back(last4);
        end
        if (!push || (rd && wr)) drops4++;
        rd_req4 = rd; wr_req4 = wr; addr4 = a; wdata4 = d;
        @(posedge clk); #1;
        rd_req4 = 1'b0; wr_req4 = 1'b0;
    endtask

    task automatic lat_check4(input string name);
        for (int k = 1; k < 4; k++) begin
            check({name, "_busy"}, 32'(busy4), 32'd1);
            check({name, "_noack"}, 32'(ack4), 32'd0);
            @(posedge clk); #1;
        end
        check({name, "_ack"}, 32'(ack4), 32'd1);
        check({name, "_ackbusy"}, 32'(busy4), 32'd0);
    endtask

    task automatic wait_ack4(input string name);
        int n = 0;
        while (!ack4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(ack4), 32'd1);
    endtask

    task automatic req1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (wr) m1[widx(a)] = d;
        else last1 = m1[widx(a)];
        q1.push_back(last1);
        rd_req1 = rd; wr_req1 = wr; addr1 = a; wdata1 = d;
        @(posedge clk); #1;
        check("lat1_ack", 32'(ack1), 32'd1);
        check("lat1_busy", 32'(busy1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_ack", 32'(ack4), 32'd0);
        check("rst_rd_data", rd_data4, 32'd0);
        check("rst_drop", 32'(drop4), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);

        // Write then read-after-write issued in the write's ack cycle.
        req4(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        lat_check4("wr10");
        req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        lat_check4("rd10");

        // Read, then a write while busy: ignored and counted.
        req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        req4(1'b0, 1'b1, 32'h10, 32'h11111111, 1'b0);
        wait_ack4("rd_busy_ack");
        check("drop_after_busy", 32'(drop4), STATS ? 32'(drops4) : 32'd0);
        req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        lat_check4("rd10_again");

        // Simultaneous read and write: write wins, one ack, one drop.
        req4(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 1'b1);
        lat_check4("rdwr8");
        check("drop_after_rdwr", 32'(drop4), STATS ? 32'(drops4) : 32'd0);
        req4(1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
        lat_check4("rd8");

        // Reset mid-read: abandoned with no ack, array kept.
        @(posedge clk); #1;
        req4(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_ack", 32'(ack4), 32'd0);
        check("midrst_rd_data", rd_data4, 32'd0);
        check("midrst_drop", 32'(drop4), 32'd0);
        last4 = '0;
        drops4 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        req4(1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
        lat_check4("after_rst");

        // Aliasing: 0x1000 and 0x0 map to word 0.
        req4(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 1'b1);
        lat_check4("wr1000");
        req4(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        lat_check4("rd0_alias");

        // LATENCY=1 alternating traffic, one request every cycle.
        req1(1'b0, 1'b1, 32'h0, 32'hA1A1A1A1);
        req1(1'b0, 1'b1, 32'h4, 32'hB1B1B1B1);
        req1(1'b1, 1'b0, 32'h0, 32'h0);
        req1(1'b1, 1'b0, 32'h4, 32'h0);
        req1(1'b0, 1'b1, 32'h0, 32'hA2A2A2A2);
        req1(1'b1, 1'b0, 32'h0, 32'h0);
        req1(1'b0, 1'b1, 32'h4, 32'hB2B2B2B2);
        req1(1'b1, 1'b0, 32'h4, 32'h0);
        rd_req1 = 1'b0; wr_req1 = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("drop1_none", 32'(drop1), 32'd0);
        check("idle_busy4", 32'(busy4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's single-outstanding-request memory protocol. It accepts one-cycle read/write request pulses, commits writes and captures reads into a word-addressed on-chip array, and after a fixed configurable latency returns a one-cycle `ack` with read data. It sits at the memory end of the core–memory link and is the counterpart of the core's request issuer. It is used as the default memory model in core-level benches and timing runs.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width. Must be 32.
- `DEPTH`, default 1024: number of words. Must be a power of two and at least 2.
- `LATENCY`, default 4: cycles from request acceptance to `ack`. Must be at least 1.

Ports (name, direction, width, meaning):
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rd_req` input 1: read request pulse.
- `wr_req` input 1: write request pulse.
- `addr` input ADDR_WIDTH: byte address, sampled with the request.
- `wr_data` input DATA_WIDTH: write data, sampled with `wr_req`.
- `busy` output 1: a request is in flight and no new request is accepted.
- `ack` output 1: one-cycle completion pulse.
- `rd_data` output DATA_WIDTH: read result. Valid when `ack` is high after a read.
- `drop_count` output 16: count of ignored requests (see Configuration).

## Operation
- FSM states:
  - IDLE: no request in flight.
  - WAIT: counting down latency.
  - ACK: `ack` high.
- A request is accepted on a rising edge where (`rd_req` or `wr_req`) is high and the state is IDLE or ACK.
- Transitions on acceptance:
  - LATENCY=1: go to ACK.
  - Otherwise: go to WAIT, with the counter loaded to LATENCY-2.
- WAIT: the counter decrements each cycle. When it is 0, go to ACK.
- ACK with no new request: go to IDLE.
- Word index is `addr[2 +: $clog2(DEPTH)]`. `addr[1:0]` and higher bits are ignored, so out-of-range addresses alias by truncation.
- Write: the array is updated on the acceptance edge.
- Read: the array word is captured into a read register on the acceptance edge. `rd_data` drives that register and holds it until the next accepted read. A write ack leaves `rd_data` unchanged.
- `rd_req` and `wr_req` high together: the write is performed, the read is discarded, and the event counts as one drop.
- Request while `busy`: ignored completely, with no array update. It counts as one drop.
- Array contents are not reset.

## Timing
- Request accepted at edge T:
  - `busy` = 1 during cycles T+1 .. T+LATENCY-1.
  - `ack` = 1 during cycle T+LATENCY only, with `busy` = 0 in that cycle.
- LATENCY=1: `busy` never rises, and `ack` is high in the cycle after the request.
- Back-to-back: a request presented in the `ack` cycle is accepted. Throughput is therefore one request per LATENCY cycles.
- Read-after-write: a read accepted in the write's `ack` cycle returns the new data.
- `ack`, `busy` and `rd_data` are registered outputs with no combinational path from the inputs.
- Reset values: state IDLE, `busy`=0, `ack`=0, `rd_data`=0, counter 0, `drop_count`=0.
- Reset asserted mid-operation:
  - The in-flight request is abandoned and no `ack` is issued.
  - A write already committed stays in the array.

## Configuration
- `MEM_RESPONDER_STATS_EN` defined:
  - `drop_count` increments by 1 per dropped request (request while busy, or simultaneous rd/wr).
  - It saturates at 16'hFFFF.
  - It is cleared only by `rst`.
- Not defined: `drop_count` is tied to 0 and no counter logic is generated.

## Structure
- Package `mem_responder_pkg` contains:
  - the state enum `mem_resp_state_e` (IDLE, WAIT, ACK);
  - the constant `MEM_RESP_DROP_W` = 16.
- Sub-module `mem_responder_ram`:
  - single-port synchronous array, DEPTH x DATA_WIDTH;
  - write enable and registered read;
  - no reset on the storage.
- The top level holds the FSM, the latency counter, the drop counter and the address decode.

## Test plan
- Reset, LATENCY=4: write 0xDEADBEEF to 0x10 at T, then read 0x10 in the write's ack cycle → `ack` at T+4 and T+8; `rd_data`=0xDEADBEEF at T+8; `busy` high T+1..T+3.
- LATENCY=1: alternate writes and reads to 0x0 and 0x4 every cycle → `ack` every cycle, `busy` always 0, and each read returns the last value written to its address.
- Read accepted at T with a `wr_req` to the same address at T+2 → write ignored, array unchanged; with the macro defined, `drop_count`=1.
- `rd_req` and `wr_req` both high with 0x5A5A5A5A at 0x8 → one `ack`; a later read of 0x8 returns 0x5A5A5A5A; `rd_data` unchanged at the first ack; `drop_count` increments by 1.
- `rst` pulsed at T+2 of a LATENCY=4 read → no `ack` at T+4; `busy`=0 and `rd_data`=0 immediately; the next request completes normally.
- Address aliasing, DEPTH=1024: write to 0x1000, read from 0x0 → returns the written value.
